// File: rtl/ram_pkg.sv
// Shared constants for the RAM responder: data width, latency ceiling and stall LFSR setup.
`include "config.svh"
package ram_pkg;
  localparam int XLEN = `XLEN;
  localparam int LAT_MAX = 4;

  // Fibonacci LFSR, taps 16,14,13,11 expressed as a mask over bits [15:0]
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/config.svh
// Build-wide configuration shared by the RAM responder slice.
`ifndef CONFIG_SVH
`define CONFIG_SVH
`define XLEN 32
`endif

// File: rtl/sp_ram.sv
// Single-port word array with per-byte write enables and a registered (synchronous) read port.
module sp_ram
  import ram_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [XLEN/8-1:0] wstrb,
  input  logic [AW-1:0]     idx,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   rdata
);
  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < XLEN/8; b++) begin
          if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end
endmodule

// File: rtl/ram_responder.sv
// Request/response wrapper around sp_ram: handshake, fixed read latency pipeline, optional
// ready-stall injection compiled in only when RAM_RESP_STALL_EN is defined.
module ram_responder
  import ram_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              write,
  input  logic [XLEN/8-1:0] wstrb,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              ready,
  output logic              rvalid,
  output logic [XLEN-1:0]   rdata
);
  localparam int AW = $clog2(DEPTH);

  // Handshake: a transfer happens only on an edge where req && ready; responses cannot stall.
  logic              stall;
  logic              accept;
  logic              rd_acc;
  logic [XLEN-1:0]   ram_q;
  logic [XLEN-1:0]   out_data;
  logic [XLEN-1:0]   hold_q;
  logic [LATENCY-1:0] v_pipe;
  logic              unused_addr;

`ifdef RAM_RESP_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= lfsr_next(lfsr);
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign ready  = !rst && !stall;
  assign accept = req && ready;
  assign rd_acc = accept && !write;
  assign unused_addr = ^{addr[XLEN-1:AW+2], addr[1:0]};

  sp_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .en    (accept),
    .we    (write),
    .wstrb (wstrb),
    .idx   (addr[AW+1:2]),
    .wdata (wdata),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v_pipe <= '0;
    end else begin
      v_pipe[0] <= rd_acc;
      for (int i = 1; i < LATENCY; i++) v_pipe[i] <= v_pipe[i-1];
    end
  end

  // Data is captured at the accept edge and carried along, so later writes cannot alter it.
  generate
    if (LATENCY == 1) begin : g_lat1
      assign out_data = ram_q;
    end else begin : g_latn
      logic [XLEN-1:0] dq [LATENCY-1];
      always_ff @(posedge clk) begin
        dq[0] <= ram_q;
        for (int i = 1; i < LATENCY-1; i++) dq[i] <= dq[i-1];
      end
      assign out_data = dq[LATENCY-2];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)                      hold_q <= '0;
    else if (v_pipe[LATENCY-1])   hold_q <= out_data;
  end

  assign rvalid = v_pipe[LATENCY-1] && !rst;
  assign rdata  = rst ? '0 : (rvalid ? out_data : hold_q);
endmodule
